// File: rtl/xs3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xs3_pkg
// Purpose  : Shared constants, enums and the code-validity helper for the
//            bit-serial Excess-3 <-> BCD converter.
// Contents : XS3_OFFSET / XS3_MIN / XS3_MAX / BCD_MAX, mode_e, state_e,
//            code_invalid()
// Revision : 1.0 - initial release
// ============================================================================
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    typedef enum logic {
        MODE_XS3_TO_BCD = 1'b0,
        MODE_BCD_TO_XS3 = 1'b1
    } mode_e;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // An input nibble is flagged when it is not a legal code of the source
    // representation selected by the frame mode.
    function automatic logic code_invalid(input logic [3:0] raw, input mode_e m);
        if (m == MODE_XS3_TO_BCD)
            return (raw < XS3_MIN) || (raw > XS3_MAX);
        else
            return (raw > BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xs3_bit_slice.sv
`default_nettype none
// ============================================================================
// Module   : xs3_bit_slice
// Purpose  : One serial step of adding (BCD->XS3) or subtracting (XS3->BCD)
//            a constant bit, with the carry/borrow held between bits.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            en_i       - accepted bit this cycle (carry updates)
//            clr_i      - first bit of a nibble: carry-in forced to 0
//            mode_i     - 0 subtract (borrow), 1 add (carry)
//            a_i, c_i   - data bit, constant bit
//            sum_o      - combinational result bit
// Revision : 1.0 - initial release
// ============================================================================
module xs3_bit_slice (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    input  logic mode_i,
    input  logic a_i,
    input  logic c_i,
    output logic sum_o
);

    logic cy_q;
    logic cy_d;
    logic w_cy;

    always_comb begin
        w_cy  = clr_i ? 1'b0 : cy_q;
        sum_o = a_i ^ c_i ^ w_cy;
        if (mode_i)
            cy_d = (a_i & c_i) | (a_i & w_cy) | (c_i & w_cy);
        else
            cy_d = (~a_i & c_i) | (~a_i & w_cy) | (c_i & w_cy);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cy_q <= 1'b0;
        else if (en_i)
            cy_q <= cy_d;
    end

endmodule
`default_nettype wire

// File: rtl/xs3_bcd_serial_conv.sv
`default_nettype none
// ============================================================================
// Module   : xs3_bcd_serial_conv
// Purpose  : Bit-serial multi-digit Excess-3 <-> BCD converter. Input is LSB
//            first per nibble, digit0 first. Emits converted serial bits,
//            each assembled digit and the whole frame word, and flags
//            invalid input codes.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            mode                      - 0 XS3->BCD, 1 BCD->XS3 (frame latched)
//            in_valid, in_bit, in_sof  - serial input, sof marks bit0/digit0
//            out_valid, out_bit        - converted bit, 1 cycle latency
//            digit_valid, digit, digit_err - per-digit result pulse
//            word_valid, word, word_err    - per-frame result pulse
// Revision : 1.0 - initial release
// ============================================================================
module xs3_bcd_serial_conv
    import xs3_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int ERR_STICKY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic                  in_bit,
    input  logic                  in_sof,
    output logic                  out_valid,
    output logic                  out_bit,
    output logic                  digit_valid,
    output logic [3:0]            digit,
    output logic                  digit_err,
    output logic                  word_valid,
    output logic [4*DIGITS-1:0]   word,
    output logic                  word_err
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [1:0]            bit_cnt_q;
    logic [DW-1:0]         dig_cnt_q;
    logic [3:0]            raw_q;
    logic [3:0]            conv_q;
    logic                  err_acc_q;
    logic [4*DIGITS-1:0]   word_acc_q;

    logic                  out_valid_q, out_bit_q, digit_valid_q, digit_err_q;
    logic                  word_valid_q, word_err_q;
    logic [3:0]            digit_q;
    logic [4*DIGITS-1:0]   word_q;

    logic                  w_first;
    logic [1:0]            w_k;
    logic [DW-1:0]         w_dig;
    mode_e                 w_mode;
    logic                  w_cbit;
    logic                  w_obit;
    logic                  w_last_bit;
    logic                  w_last_dig;
    logic [3:0]            w_raw;
    logic [3:0]            w_conv;
    logic                  w_err;
    logic                  w_frame_err;
    logic [4*DIGITS-1:0]   w_word;

    // in_sof overrides the counters so the current bit is treated as bit0 of
    // digit0; the mode of the first bit of a frame comes straight from the
    // input because mode_q is only loaded on that same edge.
    always_comb begin
        w_first     = in_sof || (bit_cnt_q == 2'd0 && dig_cnt_q == '0);
        w_k         = in_sof ? 2'd0 : bit_cnt_q;
        w_dig       = in_sof ? '0   : dig_cnt_q;
        w_mode      = w_first ? mode_e'(mode) : mode_q;
        w_cbit      = XS3_OFFSET[w_k];
        w_last_bit  = (w_k == 2'd3);
        w_last_dig  = (w_dig == DW'(DIGITS - 1));

        w_raw       = raw_q;
        w_raw[w_k]  = in_bit;
        w_conv      = conv_q;
        w_conv[w_k] = w_obit;
        w_err       = code_invalid(w_raw, w_mode);
        w_frame_err = (w_first ? 1'b0 : err_acc_q) | (w_last_bit & w_err);

        w_word      = word_acc_q;
        w_word[4*int'(w_dig) +: 4] = w_conv;
    end

    xs3_bit_slice u_slice (
        .clk    (clk),
        .rst    (rst),
        .en_i   (in_valid),
        .clr_i  (w_k == 2'd0),
        .mode_i (w_mode == MODE_BCD_TO_XS3),
        .a_i    (in_bit),
        .c_i    (w_cbit),
        .sum_o  (w_obit)
    );

    // Frame-tracking FSM
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (w_last_bit && w_last_dig)
                state_d = S_IDLE;
            else
                state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_XS3_TO_BCD;
            bit_cnt_q     <= 2'd0;
            dig_cnt_q     <= '0;
            raw_q         <= 4'd0;
            conv_q        <= 4'd0;
            err_acc_q     <= 1'b0;
            word_acc_q    <= '0;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            digit_valid_q <= 1'b0;
            digit_q       <= 4'd0;
            digit_err_q   <= 1'b0;
            word_valid_q  <= 1'b0;
            word_q        <= '0;
            word_err_q    <= 1'b0;
        end else begin
            out_valid_q   <= in_valid;
            digit_valid_q <= 1'b0;
            word_valid_q  <= 1'b0;
            if (in_valid) begin
                out_bit_q  <= w_obit;
                bit_cnt_q  <= w_k + 2'd1;
                raw_q      <= w_raw;
                conv_q     <= w_conv;
                err_acc_q  <= w_frame_err;
                word_acc_q <= w_word;
                if (w_first)
                    mode_q <= mode_e'(mode);
                if (in_sof && ERR_STICKY != 0)
                    word_err_q <= 1'b0;
                if (w_last_bit) begin
                    digit_valid_q <= 1'b1;
                    digit_q       <= w_conv;
                    digit_err_q   <= w_err;
                    dig_cnt_q     <= w_last_dig ? '0 : w_dig + DW'(1);
                    if (w_last_dig) begin
                        word_valid_q <= 1'b1;
                        word_q       <= w_word;
                        word_err_q   <= (ERR_STICKY != 0) ? (word_err_q | w_frame_err)
                                                          : w_frame_err;
                    end
                end else begin
                    dig_cnt_q <= w_dig;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign digit_valid = digit_valid_q;
    assign digit       = digit_q;
    assign digit_err   = digit_err_q;
    assign word_valid  = word_valid_q;
    assign word        = word_q;
    assign word_err    = word_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xs3_bcd_serial_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_xs3_bcd_serial_conv
// Purpose  : Scoreboard bench for xs3_bcd_serial_conv. Two instances:
//            DIGITS=1 (single-nibble cases) and DIGITS=4 (frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xs3_bcd_serial_conv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DIGITS=1 instance signals
    logic        m1, v1, b1, s1;
    logic        o1_ov, o1_ob, o1_dv, o1_de, o1_wv, o1_we;
    logic [3:0]  o1_dg, o1_w;
    // DIGITS=4 instance signals
    logic        m4, v4, b4, s4;
    logic        o4_ov, o4_ob, o4_dv, o4_de, o4_wv, o4_we;
    logic [3:0]  o4_dg;
    logic [15:0] o4_w;

    xs3_bcd_serial_conv #(.DIGITS(1), .ERR_STICKY(0)) u_d1 (
        .clk(clk), .rst(rst), .mode(m1), .in_valid(v1), .in_bit(b1), .in_sof(s1),
        .out_valid(o1_ov), .out_bit(o1_ob), .digit_valid(o1_dv), .digit(o1_dg),
        .digit_err(o1_de), .word_valid(o1_wv), .word(o1_w), .word_err(o1_we)
    );

    xs3_bcd_serial_conv #(.DIGITS(4), .ERR_STICKY(0)) u_d4 (
        .clk(clk), .rst(rst), .mode(m4), .in_valid(v4), .in_bit(b4), .in_sof(s4),
        .out_valid(o4_ov), .out_bit(o4_ob), .digit_valid(o4_dv), .digit(o4_dg),
        .digit_err(o4_de), .word_valid(o4_wv), .word(o4_w), .word_err(o4_we)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: bits, {err,digit}, {err,word}
    logic        q1b[$];
    logic [4:0]  q1d[$];
    logic [4:0]  q1w[$];
    logic        q4b[$];
    logic [4:0]  q4d[$];
    logic [16:0] q4w[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: output seen with no expected entry", nm);
    endtask

    // Monitor: samples on the falling edge, pops whenever the DUT presents output
    always @(negedge clk) begin
        if (o1_ov) begin
            if (q1b.size() == 0) unexpected("d1_bit");
            else chk("d1_bit", {31'd0, o1_ob}, {31'd0, q1b.pop_front()});
        end
        if (o1_dv) begin
            if (q1d.size() == 0) unexpected("d1_digit");
            else chk("d1_digit", {27'd0, o1_de, o1_dg}, {27'd0, q1d.pop_front()});
        end
        if (o1_wv) begin
            if (q1w.size() == 0) unexpected("d1_word");
            else chk("d1_word", {27'd0, o1_we, o1_w}, {27'd0, q1w.pop_front()});
        end
        if (o4_ov) begin
            if (q4b.size() == 0) unexpected("d4_bit");
            else chk("d4_bit", {31'd0, o4_ob}, {31'd0, q4b.pop_front()});
        end
        if (o4_dv) begin
            if (q4d.size() == 0) unexpected("d4_digit");
            else chk("d4_digit", {27'd0, o4_de, o4_dg}, {27'd0, q4d.pop_front()});
        end
        if (o4_wv) begin
            if (q4w.size() == 0) unexpected("d4_word");
            else chk("d4_word", {15'd0, o4_we, o4_w}, {15'd0, q4w.pop_front()});
        end
    end

    // One cycle of drive; the unselected instance always sees in_valid=0
    task automatic drive(input int sel, input logic v, input logic b,
                         input logic s, input logic m);
        @(posedge clk);
        #1;
        v1 = 1'b0; s1 = 1'b0;
        v4 = 1'b0; s4 = 1'b0;
        if (sel == 1) begin
            v1 = v; b1 = b; s1 = s; m1 = m;
        end else begin
            v4 = v; b4 = b; s4 = s; m4 = m;
        end
    endtask

    // Send nb bits of raw (LSB first); conv/err are the hand-computed result
    task automatic nib(input int sel, input logic [3:0] raw, input logic md,
                       input logic sof, input int nb, input logic [3:0] conv,
                       input logic err, input bit gaps);
        for (int k = 0; k < nb; k++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) drive(sel, 1'b0, 1'b0, 1'b0, ~md);
            if (sel == 1) q1b.push_back(conv[k]);
            else          q4b.push_back(conv[k]);
            if (nb == 4 && k == 3) begin
                if (sel == 1) q1d.push_back({err, conv});
                else          q4d.push_back({err, conv});
            end
            drive(sel, 1'b1, raw[k], sof && (k == 0), md);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m1 = 0; v1 = 0; b1 = 0; s1 = 0;
        m4 = 0; v4 = 0; b4 = 0; s4 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_d1", {18'd0, o1_ov, o1_ob, o1_dv, o1_dg, o1_de, o1_wv, o1_w, o1_we}, 32'd0);
        chk("reset_d4", {6'd0, o4_ov, o4_ob, o4_dv, o4_dg, o4_de, o4_wv, o4_w, o4_we}, 32'd0);
        rst = 1'b0;

        // Single-digit conversions, valid and invalid codes
        q1w.push_back({1'b0, 4'h5}); nib(1, 4'h8, 1'b0, 1'b0, 4, 4'h5, 1'b0, 0);
        q1w.push_back({1'b0, 4'hC}); nib(1, 4'h9, 1'b1, 1'b1, 4, 4'hC, 1'b0, 0);
        q1w.push_back({1'b0, 4'h3}); nib(1, 4'h0, 1'b1, 1'b0, 4, 4'h3, 1'b0, 0);
        q1w.push_back({1'b1, 4'hE}); nib(1, 4'h1, 1'b0, 1'b0, 4, 4'hE, 1'b1, 0);
        q1w.push_back({1'b1, 4'hC}); nib(1, 4'hF, 1'b0, 1'b0, 4, 4'hC, 1'b1, 0);
        q1w.push_back({1'b1, 4'hD}); nib(1, 4'hA, 1'b1, 1'b0, 4, 4'hD, 1'b1, 0);

        // 4-digit XS3 frame 6,9,C,3 with gaps; mode toggled after digit0
        q4w.push_back({1'b0, 16'h0963});
        nib(4, 4'h6, 1'b0, 1'b0, 4, 4'h3, 1'b0, 1);
        nib(4, 4'h9, 1'b1, 1'b0, 4, 4'h6, 1'b0, 1);
        nib(4, 4'hC, 1'b1, 1'b0, 4, 4'h9, 1'b0, 1);
        nib(4, 4'h3, 1'b1, 1'b0, 4, 4'h0, 1'b0, 1);

        // Back-to-back frame without sof (counter wrap), last digit invalid
        q4w.push_back({1'b1, 16'hD210});
        nib(4, 4'h3, 1'b0, 1'b0, 4, 4'h0, 1'b0, 0);
        nib(4, 4'h4, 1'b0, 1'b0, 4, 4'h1, 1'b0, 0);
        nib(4, 4'h5, 1'b0, 1'b0, 4, 4'h2, 1'b0, 0);
        nib(4, 4'h0, 1'b0, 1'b0, 4, 4'hD, 1'b1, 0);

        // Frame abandoned after 6 bits by in_sof; new BCD->XS3 frame 1,2,3,4
        nib(4, 4'h5, 1'b0, 1'b1, 4, 4'h2, 1'b0, 0);
        nib(4, 4'h6, 1'b0, 1'b0, 2, 4'h3, 1'b0, 0);
        q4w.push_back({1'b0, 16'h7654});
        nib(4, 4'h1, 1'b1, 1'b1, 4, 4'h4, 1'b0, 0);
        nib(4, 4'h2, 1'b1, 1'b0, 4, 4'h5, 1'b0, 0);
        nib(4, 4'h3, 1'b1, 1'b0, 4, 4'h6, 1'b0, 0);
        nib(4, 4'h4, 1'b1, 1'b0, 4, 4'h7, 1'b0, 0);

        // Reset in the middle of a nibble on both instances
        nib(1, 4'h3, 1'b0, 1'b0, 2, 4'h0, 1'b0, 0);
        nib(4, 4'h3, 1'b0, 1'b0, 3, 4'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        v1 = 0; s1 = 0; v4 = 0; s4 = 0;
        @(posedge clk);
        #1;
        chk("midrst_d1", {18'd0, o1_ov, o1_ob, o1_dv, o1_dg, o1_de, o1_wv, o1_w, o1_we}, 32'd0);
        chk("midrst_d4", {6'd0, o4_ov, o4_ob, o4_dv, o4_dg, o4_de, o4_wv, o4_w, o4_we}, 32'd0);
        rst = 1'b0;

        // After reset, conversion restarts at bit0 without in_sof
        q1w.push_back({1'b0, 4'h5}); nib(1, 4'h8, 1'b0, 1'b0, 4, 4'h5, 1'b0, 0);
        q4w.push_back({1'b0, 16'h0963});
        nib(4, 4'h6, 1'b0, 1'b0, 4, 4'h3, 1'b0, 0);
        nib(4, 4'h9, 1'b0, 1'b0, 4, 4'h6, 1'b0, 0);
        nib(4, 4'hC, 1'b0, 1'b0, 4, 4'h9, 1'b0, 0);
        nib(4, 4'h3, 1'b0, 1'b0, 4, 4'h0, 1'b0, 0);

        repeat (6) drive(4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_pending",
            q1b.size() + q1d.size() + q1w.size() + q4b.size() + q4d.size() + q4w.size(),
            32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
